// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit single sampling,
// registered byte output with one-cycle valid / framing-error pulses.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rstb_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        meta_q, meta_d;
  logic        rx_s_q, rx_s_d;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      meta_q  <= meta_d;
      rx_s_q  <= rx_s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    meta_d  = rx_i;
    rx_s_d  = meta_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          // a start bit that is gone by mid-bit was a glitch
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d        = '0;
          shreg_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if (rx_s_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      BREAK: begin
        // wait out a held-low line before arming start detection again
        timer_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign data_o      = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
// Each scenario task drives frames and checks its own results.
module tb_uart_receiver;

  localparam int N = 16;

  logic       clk_i = 1'b0;
  logic       rstb_i = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] vdata_q[$];
  int         vcyc_q[$];
  int         fcnt = 0;
  int         both = 0;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk_i       (clk_i),
    .rstb_i      (rstb_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .rx_valid_o  (rx_valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rx_valid_o) begin
      vdata_q.push_back(data_o);
      vcyc_q.push_back(cyc);
    end
    if (frame_err_o) fcnt++;
    if (rx_valid_o && frame_err_o) both++;
  end

  task automatic clear();
    vdata_q.delete();
    vcyc_q.delete();
    fcnt = 0;
    both = 0;
  endtask

  // px = bit period in hundredths of a clock cycle; called at a negedge
  task automatic send(input logic [7:0] b, input logic stopb,
                      input int px);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx_i = fr[j];
      repeat (((j + 1) * px) / 100 - (j * px) / 100) @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rstb_i = 1'b0;
    rx_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({data_o, rx_valid_o, frame_err_o, busy_o} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000",
               {data_o, rx_valid_o, frame_err_o, busy_o});
    end
    rstb_i = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: busy=%b data=%h expected 0/00",
               busy_o, data_o);
    end
  endtask

  task automatic test_basic();
    int k;
    int exp_c;
    clear();
    k = cyc;
    send(8'hA5, 1'b1, 1600);
    repeat (10) @(negedge clk_i);
    checks++;
    if (vdata_q.size() != 1) begin
      errors++;
      $display("FAIL basic_pulses: got %0d expected 1", vdata_q.size());
    end else begin
      checks++;
      if (vdata_q[0] !== 8'hA5) begin
        errors++;
        $display("FAIL basic_data: got %h expected a5", vdata_q[0]);
      end
      exp_c = k + 2 + N / 2 + 9 * N + 1;
      checks++;
      if (vcyc_q[0] < exp_c - 1 || vcyc_q[0] > exp_c + 1) begin
        errors++;
        $display("FAIL basic_latency: got cycle %0d expected %0d",
                 vcyc_q[0], exp_c);
      end
    end
    checks++;
    if (fcnt != 0 || busy_o !== 1'b0 || data_o !== 8'hA5) begin
      errors++;
      $display("FAIL basic_after: ferr=%0d busy=%b data=%h exp 0/0/a5",
               fcnt, busy_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear();
    send(8'h00, 1'b1, 1600);
    send(8'hFF, 1'b1, 1600);
    repeat (10) @(negedge clk_i);
    checks++;
    if (vdata_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d expected 2", vdata_q.size());
    end else begin
      checks++;
      if (vdata_q[0] !== 8'h00 || vdata_q[1] !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_data: got %h %h expected 00 ff",
                 vdata_q[0], vdata_q[1]);
      end
      d = vcyc_q[1] - vcyc_q[0];
      checks++;
      if (d < 10 * N - 1 || d > 10 * N + 1) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d expected %0d", d, 10 * N);
      end
    end
    checks++;
    if (fcnt != 0 || both != 0) begin
      errors++;
      $display("FAIL b2b_ferr: got %0d/%0d expected 0/0", fcnt, both);
    end
  endtask

  task automatic test_glitch();
    clear();
    rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (30) @(negedge clk_i);
    checks++;
    if (vdata_q.size() != 0 || fcnt != 0) begin
      errors++;
      $display("FAIL glitch_pulses: valid=%0d ferr=%0d expected 0/0",
               vdata_q.size(), fcnt);
    end
    checks++;
    if (data_o !== 8'hFF || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_state: data=%h busy=%b expected ff/0",
               data_o, busy_o);
    end
  endtask

  task automatic test_frame_err();
    clear();
    send(8'h3C, 1'b0, 1600);
    repeat (40) @(negedge clk_i);
    checks++;
    if (fcnt != 1 || vdata_q.size() != 0 || both != 0) begin
      errors++;
      $display("FAIL ferr_pulses: ferr=%0d valid=%0d expected 1/0",
               fcnt, vdata_q.size());
    end
    checks++;
    if (data_o !== 8'hFF || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ferr_break: data=%h busy=%b expected ff/1",
               data_o, busy_o);
    end
    rx_i = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr_exit: busy=%b expected 0", busy_o);
    end
    send(8'h81, 1'b1, 1600);
    repeat (10) @(negedge clk_i);
    checks++;
    if (vdata_q.size() != 1 || data_o !== 8'h81 || fcnt != 1) begin
      errors++;
      $display("FAIL ferr_recover: n=%0d data=%h ferr=%0d exp 1/81/1",
               vdata_q.size(), data_o, fcnt);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    b = 8'h5A;
    clear();
    rx_i = 1'b0;
    repeat (N) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      repeat (N) @(negedge clk_i);
    end
    rx_i = b[4];
    repeat (N / 2) @(negedge clk_i);
    rstb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({data_o, rx_valid_o, frame_err_o, busy_o} !== 11'h0) begin
      errors++;
      $display("FAIL abort_in_reset: got %h expected 000",
               {data_o, rx_valid_o, frame_err_o, busy_o});
    end
    rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    rstb_i = 1'b1;
    repeat (30) @(negedge clk_i);
    checks++;
    if (vdata_q.size() != 0 || fcnt != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: valid=%0d ferr=%0d busy=%b exp 0/0/0",
               vdata_q.size(), fcnt, busy_o);
    end
    send(8'hC3, 1'b1, 1600);
    repeat (10) @(negedge clk_i);
    checks++;
    if (vdata_q.size() != 1 || data_o !== 8'hC3) begin
      errors++;
      $display("FAIL abort_next: n=%0d data=%h expected 1/c3",
               vdata_q.size(), data_o);
    end
  endtask

  task automatic test_rate_sweep();
    int         pxs[6];
    logic [7:0] bs[6];
    pxs = '{1552, 1568, 1584, 1616, 1632, 1648};
    bs  = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h96, 8'h69};
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 6; i++) begin
        clear();
        send(bs[(i + p) % 6], 1'b1, pxs[p]);
        repeat (20) @(negedge clk_i);
        checks++;
        if (vdata_q.size() != 1 || fcnt != 0 ||
            data_o !== bs[(i + p) % 6]) begin
          errors++;
          $display("FAIL sweep_px%0d: n=%0d data=%h ferr=%0d exp 1/%h/0",
                   pxs[p], vdata_q.size(), data_o, fcnt,
                   bs[(i + p) % 6]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
    test_rate_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk_i cycles per UART bit (100 MHz / 115200); legal range 8..65535.
REQ-002 clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 rstb_i  input  1  asynchronous active-low reset.
REQ-004 rx_i  input  1  serial line, asynchronous to clk_i, idle high.
REQ-005 data_o  output  8  last correctly framed byte received.
REQ-006 rx_valid_o  output  1  one-cycle pulse when data_o is updated.
REQ-007 frame_err_o  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 busy_o  output  1  high in every state except IDLE.

Function
REQ-009 The block SHALL pass rx_i through a 2-flop synchronizer (rx_s); both flops reset to 1; all decisions use rx_s only.
REQ-010 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 The block SHALL use a 16-bit bit-timer counter and a 3-bit bit index.
REQ-012 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: timer held 0; rx_s==0 -> START with timer=0.
REQ-014 START: timer increments each cycle; at timer==CLKS_PER_BIT/2-1 (integer division), sample rx_s: 0 -> DATA with timer=0 and index=0; 1 -> IDLE (glitch reject, no pulse).
REQ-015 DATA: at timer==CLKS_PER_BIT-1, shift rx_s into bit [index] of the shift register, timer=0; at index==7 -> STOP, else index+1.
REQ-016 STOP: at timer==CLKS_PER_BIT-1, sample rx_s: 1 -> load data_o from shift register, pulse rx_valid_o, go IDLE; 0 -> pulse frame_err_o, data_o unchanged, go BREAK.
REQ-017 BREAK: stay until rx_s==1, then go IDLE; no start detection while in BREAK.
REQ-018 rx_valid_o and frame_err_o SHALL never be high in the same cycle and SHALL each be high exactly one cycle per frame.
REQ-019 Latency: rx_valid_o SHALL assert CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+/-1) after the first cycle rx_s is low.
REQ-020 A new start bit SHALL be accepted in the first IDLE cycle after STOP, so back-to-back frames with a single stop bit are received without loss.
REQ-021 rx_i changes mid-bit outside sample points SHALL have no effect (single-sample, mid-bit).
REQ-022 data_o SHALL hold its value between frames and across framing errors.

Reset
REQ-023 rstb_i low SHALL immediately force state=IDLE, timer=0, index=0, shift register=0, data_o=8'h00, rx_valid_o=0, frame_err_o=0, busy_o=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the block SHALL wait for the next rx_s falling level in IDLE.
REQ-025 Reset release SHALL be synchronous to clk_i at the system level; the block adds no reset synchronizer.

Verification (CLKS_PER_BIT=16)
REQ-026 Send 0xA5 with a valid stop bit -> rx_valid_o one pulse, data_o=8'hA5, frame_err_o stays 0, busy_o low afterwards.
REQ-027 Send 0x00 then 0xFF back-to-back with one stop bit -> two rx_valid_o pulses 160 cycles apart (+/-1), data_o=8'h00 then 8'hFF.
REQ-028 Drive rx_i low for 4 cycles, then high -> START returns to IDLE, no rx_valid_o, no frame_err_o, data_o unchanged.
REQ-029 Send 0x3C with stop bit 0, hold rx_i low 40 cycles, then send 0x81 -> one frame_err_o pulse, data_o keeps its previous value, block stays in BREAK until rx_i is high, then 0x81 is received correctly.
REQ-030 Assert rstb_i during data bit 4 of 0x5A, release, send 0xC3 -> no pulse for the aborted frame, all outputs 0 during reset, data_o=8'hC3 after the next frame.
REQ-031 Sweep the sender bit period by +/-3% relative to CLKS_PER_BIT for random bytes -> all bytes received correctly, no frame_err_o.
